instruction_decode: RTL and testbench

- Instruction-decode (ID) stage of the 5-stage 32-bit MIPS-style pipeline. Sits between the IF/ID and ID/EX boundaries.
- Holds the 32x32 register file, generates main control, and sign-extends the immediate.
- Registers all results into the ID/EX pipeline register.
- Register-file writes arrive from the write-back stage.

---
 rtl/instruction_decode.sv | 171 +++++++++++++++++
 tb/tb_instruction_decode.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// instruction_decode: ID stage of the 5-stage 32-bit MIPS-style pipeline.
//
// Holds the 32x32 register file (written from WB), decodes main control from
// the opcode, sign-extends the immediate and registers everything into the
// ID/EX pipeline register. Latency is one clock from instruction to outputs.
//
// Ports:
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous active-high reset; clears regfile and outputs
//   programCounterIn    in   [31:0] PC+4 from IF/ID
//   instruction         in   [31:0] instruction word from IF/ID
//   writeRegister       in   [4:0]  regfile write index from WB
//   writeData           in   [31:0] regfile write data from WB
//   regWrite            in   regfile write enable from WB
//   writeBackControl    out  [1:0]  {RegWrite, MemtoReg}
//   memAccessControl    out  [2:0]  {Branch, MemRead, MemWrite}
//   calculationControl  out  [3:0]  {RegDst, ALUOp[1:0], ALUSrc}
//   programCounterOut   out  [31:0] registered PC+4
//   readData1           out  [31:0] registered rs value
//   readData2           out  [31:0] registered rt value
//   immediateOperand    out  [31:0] registered sign-extended imm16
//   writeRegister0      out  [4:0]  registered rt field
//   writeRegister1      out  [4:0]  registered rd field
//
// Build option:
//   ID_WRITE_BYPASS_EN  when defined, a WB write that hits rs/rt in the same
//                       cycle forwards writeData into readData1/readData2.
//                       Otherwise the pre-write register contents are captured.

module instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] programCounterIn,
  input  logic [31:0] instruction,
  input  logic [4:0]  writeRegister,
  input  logic [31:0] writeData,
  input  logic        regWrite,
  output logic [1:0]  writeBackControl,
  output logic [2:0]  memAccessControl,
  output logic [3:0]  calculationControl,
  output logic [31:0] programCounterOut,
  output logic [31:0] readData1,
  output logic [31:0] readData2,
  output logic [31:0] immediateOperand,
  output logic [4:0]  writeRegister0,
  output logic [4:0]  writeRegister1
);

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;

  // Field decode
  logic [5:0]  opcode;
  logic [4:0]  rsIndex;
  logic [4:0]  rtIndex;
  logic [4:0]  rdIndex;
  logic [15:0] imm16;

  assign opcode  = instruction[31:26];
  assign rsIndex = instruction[25:21];
  assign rtIndex = instruction[20:16];
  assign rdIndex = instruction[15:11];
  assign imm16   = instruction[15:0];

  // Register file
  logic [31:0] registerFile [32];
  logic        writeEnable;

  // Writes to $0 are dropped so it always reads as zero.
  assign writeEnable = regWrite && (writeRegister != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        registerFile[i] <= 32'd0;
      end
    end else if (writeEnable) begin
      registerFile[writeRegister] <= writeData;
    end
  end

  // Read ports
  logic [31:0] rsValue;
  logic [31:0] rtValue;

  always_comb begin
    rsValue = (rsIndex == 5'd0) ? 32'd0 : registerFile[rsIndex];
    rtValue = (rtIndex == 5'd0) ? 32'd0 : registerFile[rtIndex];
`ifdef ID_WRITE_BYPASS_EN
    // Same-edge WB write wins over the stale array value.
    if (writeEnable && (writeRegister == rsIndex)) begin
      rsValue = writeData;
    end
    if (writeEnable && (writeRegister == rtIndex)) begin
      rtValue = writeData;
    end
`endif
  end

  // Main control decode
  logic [3:0] calcNext;
  logic [2:0] memNext;
  logic [1:0] wbNext;

  always_comb begin
    // Unknown opcodes become a bubble: all control low.
    calcNext = 4'b0000;
    memNext  = 3'b000;
    wbNext   = 2'b00;
    case (opcode)
      OpRType: begin
        calcNext = 4'b1100;
        wbNext   = 2'b10;
      end
      OpLw: begin
        calcNext = 4'b0001;
        memNext  = 3'b010;
        wbNext   = 2'b11;
      end
      OpSw: begin
        calcNext = 4'b0001;
        memNext  = 3'b001;
      end
      OpBeq: begin
        calcNext = 4'b0010;
        memNext  = 3'b100;
      end
      OpAddi: begin
        calcNext = 4'b0001;
        wbNext   = 2'b10;
      end
      default: begin
        calcNext = 4'b0000;
        memNext  = 3'b000;
        wbNext   = 2'b00;
      end
    endcase
  end

  logic [31:0] immExtended;
  assign immExtended = {{16{imm16[15]}}, imm16};

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeBackControl   <= 2'b00;
      memAccessControl   <= 3'b000;
      calculationControl <= 4'b0000;
      programCounterOut  <= 32'd0;
      readData1          <= 32'd0;
      readData2          <= 32'd0;
      immediateOperand   <= 32'd0;
      writeRegister0     <= 5'd0;
      writeRegister1     <= 5'd0;
    end else begin
      writeBackControl   <= wbNext;
      memAccessControl   <= memNext;
      calculationControl <= calcNext;
      programCounterOut  <= programCounterIn;
      readData1          <= rsValue;
      readData2          <= rtValue;
      immediateOperand   <= immExtended;
      writeRegister0     <= rtIndex;
      writeRegister1     <= rdIndex;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

  logic        clk;
  logic        reset;
  logic [31:0] programCounterIn;
  logic [31:0] instruction;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        regWrite;
  logic [1:0]  writeBackControl;
  logic [2:0]  memAccessControl;
  logic [3:0]  calculationControl;
  logic [31:0] programCounterOut;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] immediateOperand;
  logic [4:0]  writeRegister0;
  logic [4:0]  writeRegister1;

  int passed = 0;
  int total  = 0;

  instruction_decode dut (
    .clk                (clk),
    .reset              (reset),
    .programCounterIn   (programCounterIn),
    .instruction        (instruction),
    .writeRegister      (writeRegister),
    .writeData          (writeData),
    .regWrite           (regWrite),
    .writeBackControl   (writeBackControl),
    .memAccessControl   (memAccessControl),
    .calculationControl (calculationControl),
    .programCounterOut  (programCounterOut),
    .readData1          (readData1),
    .readData2          (readData2),
    .immediateOperand   (immediateOperand),
    .writeRegister0     (writeRegister0),
    .writeRegister1     (writeRegister1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    programCounterIn = 32'd0;
    instruction = 32'd0;
    writeRegister = 5'd0;
    writeData = 32'd0;
    regWrite = 1'b0;
    #1;
    total++;
    if ({writeBackControl, memAccessControl, calculationControl, programCounterOut, readData1,
         readData2, immediateOperand, writeRegister0, writeRegister1} !== 180'd0)
      $display("FAIL reset_outputs: got ctrl=%b pc=%h rd1=%h rd2=%h imm=%h",
               {calculationControl, memAccessControl, writeBackControl}, programCounterOut,
               readData1, readData2, immediateOperand);
    else passed++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reg_write_read();
    // Write $1 and $2 from WB
    regWrite = 1'b1; writeRegister = 5'd1; writeData = 32'h1111_1111;
    tick();
    writeRegister = 5'd2; writeData = 32'h2222_2222;
    tick();
    regWrite = 1'b0;
    programCounterIn = 32'd200;
    instruction = 32'h0022_1820;  // add $3,$1,$2
    tick();
    total++;
    if ({readData1, readData2} !== {32'h1111_1111, 32'h2222_2222})
      $display("FAIL add_read: got rd1=%h rd2=%h expected 11111111 22222222",
               readData1, readData2);
    else passed++;
    total++;
    if ({writeRegister0, writeRegister1} !== {5'd2, 5'd3})
      $display("FAIL add_dest: got rt=%0d rd=%0d expected 2 3", writeRegister0, writeRegister1);
    else passed++;
    total++;
    if (immediateOperand !== 32'h0000_1820)
      $display("FAIL add_imm: got %h expected 00001820", immediateOperand);
    else passed++;
    total++;
    if ({calculationControl, memAccessControl, writeBackControl} !== 9'b1100_000_10)
      $display("FAIL add_ctrl: got %b expected 110000010",
               {calculationControl, memAccessControl, writeBackControl});
    else passed++;
    total++;
    if (programCounterOut !== 32'd200)
      $display("FAIL add_pc: got %0d expected 200", programCounterOut);
    else passed++;
  endtask

  // lw, sw, beq, addi, unknown issued on consecutive cycles
  task automatic test_back_to_back();
    instruction = 32'h8C25_FFFC;  // lw $5,-4($1)
    programCounterIn = 32'd204;
    tick();
    total++;
    if ({calculationControl, memAccessControl, writeBackControl} !== 9'b0001_010_11)
      $display("FAIL lw_ctrl: got %b expected 000101011",
               {calculationControl, memAccessControl, writeBackControl});
    else passed++;
    total++;
    if ({immediateOperand, writeRegister0, readData1} !== {32'hFFFF_FFFC, 5'd5, 32'h1111_1111})
      $display("FAIL lw_data: got imm=%h rt=%0d rd1=%h expected fffffffc 5 11111111",
               immediateOperand, writeRegister0, readData1);
    else passed++;

    instruction = 32'hAC25_0008;  // sw $5,8($1)
    programCounterIn = 32'd208;
    tick();
    total++;
    if ({calculationControl, memAccessControl, writeBackControl} !== 9'b0001_001_00)
      $display("FAIL sw_ctrl: got %b expected 000100100",
               {calculationControl, memAccessControl, writeBackControl});
    else passed++;
    total++;
    if ({immediateOperand, programCounterOut} !== {32'h0000_0008, 32'd208})
      $display("FAIL sw_data: got imm=%h pc=%0d expected 00000008 208",
               immediateOperand, programCounterOut);
    else passed++;

    instruction = 32'h1022_0003;  // beq $1,$2,3
    tick();
    total++;
    if ({calculationControl, memAccessControl, writeBackControl} !== 9'b0010_100_00)
      $display("FAIL beq_ctrl: got %b expected 001010000",
               {calculationControl, memAccessControl, writeBackControl});
    else passed++;
    total++;
    if (readData2 !== 32'h2222_2222)
      $display("FAIL beq_rd2: got %h expected 22222222", readData2);
    else passed++;

    instruction = 32'h2023_0007;  // addi $3,$1,7
    tick();
    total++;
    if ({calculationControl, memAccessControl, writeBackControl} !== 9'b0001_000_10)
      $display("FAIL addi_ctrl: got %b expected 000100010",
               {calculationControl, memAccessControl, writeBackControl});
    else passed++;

    instruction = 32'hFC22_8005;  // opcode 0x3F
    programCounterIn = 32'd220;
    tick();
    total++;
    if ({calculationControl, memAccessControl, writeBackControl} !== 9'd0)
      $display("FAIL unknown_ctrl: got %b expected 000000000",
               {calculationControl, memAccessControl, writeBackControl});
    else passed++;
    total++;
    if ({readData1, immediateOperand, programCounterOut}
        !== {32'h1111_1111, 32'hFFFF_8005, 32'd220})
      $display("FAIL unknown_data: got rd1=%h imm=%h pc=%0d expected 11111111 ffff8005 220",
               readData1, immediateOperand, programCounterOut);
    else passed++;
  endtask

  task automatic test_reg_zero();
    regWrite = 1'b1; writeRegister = 5'd0; writeData = 32'hDEAD_BEEF;
    instruction = 32'h0000_0000;
    tick();
    regWrite = 1'b0;
    instruction = 32'h0000_1020;  // rs=0, rt=0
    tick();
    total++;
    if ({readData1, readData2} !== 64'd0)
      $display("FAIL reg_zero: got rd1=%h rd2=%h expected 0 0", readData1, readData2);
    else passed++;
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] expectFirst;
`ifdef ID_WRITE_BYPASS_EN
    expectFirst = 32'hABCD_0123;
`else
    expectFirst = 32'h0000_0000;  // $4 never written since reset
`endif
    instruction = 32'h0084_2020;  // add $4,$4,$4
    regWrite = 1'b1; writeRegister = 5'd4; writeData = 32'hABCD_0123;
    tick();
    regWrite = 1'b0;
    total++;
    if ({readData1, readData2} !== {expectFirst, expectFirst})
      $display("FAIL same_cycle: got rd1=%h rd2=%h expected %h", readData1, readData2,
               expectFirst);
    else passed++;
    tick();
    total++;
    if ({readData1, readData2} !== {32'hABCD_0123, 32'hABCD_0123})
      $display("FAIL next_cycle: got rd1=%h rd2=%h expected abcd0123", readData1, readData2);
    else passed++;
  endtask

  task automatic test_mid_run_reset();
    instruction = 32'h8C25_FFFC;  // leave non-zero outputs in flight
    programCounterIn = 32'd300;
    tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({writeBackControl, memAccessControl, calculationControl, programCounterOut, readData1,
         readData2, immediateOperand, writeRegister0, writeRegister1} !== 180'd0)
      $display("FAIL async_reset: got pc=%h rd1=%h imm=%h ctrl=%b", programCounterOut,
               readData1, immediateOperand,
               {calculationControl, memAccessControl, writeBackControl});
    else passed++;
    tick();
    reset = 1'b0;
    programCounterIn = 32'd100;
    instruction = 32'h0000_0000;
    tick();
    total++;
    if (programCounterOut !== 32'd100)
      $display("FAIL reset_pc: got %0d expected 100", programCounterOut);
    else passed++;
    total++;
    if ({calculationControl, memAccessControl, writeBackControl, readData1, readData2,
         immediateOperand} !== {9'b1100_000_10, 96'd0})
      $display("FAIL reset_nop: got ctrl=%b rd1=%h rd2=%h imm=%h",
               {calculationControl, memAccessControl, writeBackControl}, readData1, readData2,
               immediateOperand);
    else passed++;
    // Register file must have been cleared by reset
    instruction = 32'h0022_1820;
    tick();
    total++;
    if ({readData1, readData2} !== 64'd0)
      $display("FAIL regfile_cleared: got rd1=%h rd2=%h expected 0 0", readData1, readData2);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_reg_write_read();
    test_back_to_back();
    test_reg_zero();
    test_same_cycle_write();
    test_mid_run_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
